// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - round-robin sweep sequencer driving a shared 4-bit up/down counter
module count_seq_ctrl #(
    parameter int W    = 4,
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_start,
    input  logic [NREQ*W-1:0] req_target,
    input  logic [NREQ-1:0]   req_dir,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              gnt_id,
    input  logic [W-1:0]      count,
    output logic [W-1:0]      d_in,
    output logic              load,
    output logic              up_dn
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state;
    logic           rr_ptr;
    logic           gnt_q;
    logic [W-1:0]   cap_start;
    logic [W-1:0]   cap_target;
    logic           cap_dir;

    logic           any_req;
    logic           grant;
    logic [W-1:0]   nxt;
    logic [W-1:0]   sel_start;
    logic [W-1:0]   sel_target;
    logic           sel_dir;

    // rr_ptr names the requester that wins a tie; the winner hands priority to the other
    always_comb begin
        any_req    = |req_valid;
        grant      = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
        sel_start  = grant ? req_start[2*W-1:W]  : req_start[W-1:0];
        sel_target = grant ? req_target[2*W-1:W] : req_target[W-1:0];
        sel_dir    = grant ? req_dir[1] : req_dir[0];
        nxt        = cap_dir ? count + 1'b1 : count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            gnt_q      <= 1'b0;
            cap_start  <= '0;
            cap_target <= '0;
            cap_dir    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_q      <= grant;
                        rr_ptr     <= ~grant;
                        cap_start  <= sel_start;
                        cap_target <= sel_target;
                        cap_dir    <= sel_dir;
                        state      <= LOAD;
                    end
                end
                LOAD:    state <= (cap_start == cap_target) ? DONE : RUN;
                RUN:     if (nxt == cap_target) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outside RUN the counter is always loaded, so it holds its value while idle
    always_comb begin
        req_ready = '0;
        done      = '0;
        busy      = 1'b0;
        gnt_id    = 1'b0;
        d_in      = '0;
        load      = 1'b0;
        up_dn     = 1'b0;
        if (!rst) begin
            gnt_id = gnt_q;
            case (state)
                IDLE: begin
                    load = 1'b1;
                    d_in = count;
                    if (any_req) req_ready = grant ? 2'b10 : 2'b01;
                end
                LOAD: begin
                    busy = 1'b1;
                    load = 1'b1;
                    d_in = cap_start;
                end
                RUN: begin
                    busy  = 1'b1;
                    up_dn = cap_dir;
                end
                DONE: begin
                    busy = 1'b1;
                    load = 1'b1;
                    d_in = count;
                    done = gnt_q ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end

endmodule
